// File: rtl/sample_averager.sv
// Windowed sample averager.
// Accumulates 2^LOG2_N valid samples, then presents the window sum and the
// truncated average through a valid/ready handshake. A completed window that
// finds the output slot still occupied is dropped, and the sticky overrun flag
// is set.
module sample_averager #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LOG2_N = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [DATA_W-1:0]        i_data,
  input  logic                     i_valid,
  input  logic                     i_clear,
  output logic [DATA_W+LOG2_N-1:0] o_sum,
  output logic [DATA_W-1:0]        o_avg,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic                     o_overrun
);

  localparam int unsigned ACC_W = DATA_W + LOG2_N;

  // The last sample of a window arrives when the counter is all ones.
  localparam logic [LOG2_N-1:0] CNT_LAST = '1;

  // Output slot state: StEmpty has no result pending, StFull holds one.
  typedef enum logic {
    StEmpty = 1'b0,
    StFull  = 1'b1
  } state_e;

  state_e              r_state;
  state_e              w_state_d;
  logic [ACC_W-1:0]    r_acc;
  logic [LOG2_N-1:0]   r_cnt;
  logic [ACC_W-1:0]    r_sum;
  logic [DATA_W-1:0]   r_avg;
  logic                r_overrun;

  logic                w_accept;
  logic                w_complete;
  logic                w_slot_free;
  logic                w_load;
  logic                w_drop;
  logic [ACC_W-1:0]    w_final;

  // Datapath decode: clear outranks sample acceptance.
  always_comb begin
    w_accept    = i_valid & ~i_clear;
    w_complete  = w_accept & (r_cnt == CNT_LAST);
    // Slot is free when empty, or when the pending result leaves this edge.
    w_slot_free = (r_state == StEmpty) | i_ready;
    w_load      = w_complete & w_slot_free;
    w_drop      = w_complete & ~w_slot_free;
    // At most (N-1) full-scale samples are in r_acc here, so this cannot wrap.
    w_final     = r_acc + ACC_W'(i_data);
  end

  // Output FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StEmpty;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Output FSM next-state logic.
  always_comb begin
    w_state_d = r_state;
    if (i_clear) begin
      w_state_d = StEmpty;
    end else begin
      unique case (r_state)
        StEmpty: begin
          if (w_complete) w_state_d = StFull;
        end
        StFull: begin
          // Completion always lands in StFull: reload when drained, drop otherwise.
          if (w_complete)   w_state_d = StFull;
          else if (i_ready) w_state_d = StEmpty;
        end
        default: w_state_d = StEmpty;
      endcase
    end
  end

  // Output FSM outputs.
  always_comb begin
    o_valid = (r_state == StFull);
  end

  // Window accumulator and sample counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_complete) begin
      // Wrap straight into the next window; no idle cycle.
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_acc <= w_final;
      r_cnt <= r_cnt + LOG2_N'(1);
    end
  end

  // Result registers: only loaded when a finished window gets the slot.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sum <= '0;
      r_avg <= '0;
    end else if (w_load) begin
      r_sum <= w_final;
      r_avg <= w_final[ACC_W-1:LOG2_N];
    end
  end

  // Sticky overrun flag, cleared only by reset or clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_overrun <= 1'b0;
    end else if (i_clear) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end
  end

  assign o_sum     = r_sum;
  assign o_avg     = r_avg;
  assign o_overrun = r_overrun;

endmodule
